// File: rtl/score_fill_if.sv
// Handshake and data bundle between the matrix-fill controller and the score RAM manager.
interface score_fill_if #(
  parameter int N       = 128,
  parameter int BitAddr = $clog2(N + 1)
);
  logic                start;
  logic                signal;
  logic signed [8:0]   diag;
  logic signed [8:0]   up;
  logic signed [8:0]   left;
  logic [1:0]          char_a;
  logic [1:0]          char_b;
  logic                en_read;
  logic                en_ins;
  logic                we;
  logic                change_index;
  logic [BitAddr:0]    i;
  logic [BitAddr:0]    j;
  logic signed [8:0]   max;
  logic [1:0]          dir;
  logic                dir_valid;
  logic                busy;
  logic                done;

  // Controller side.
  modport master (
    input  start, signal, diag, up, left, char_a, char_b,
    output en_read, en_ins, we, change_index, i, j, max, dir, dir_valid, busy, done
  );

  // Score manager / environment side.
  modport slave (
    output start, signal, diag, up, left, char_a, char_b,
    input  en_read, en_ins, we, change_index, i, j, max, dir, dir_valid, busy, done
  );
endinterface

// File: rtl/score_fill_controller.sv
// Needleman-Wunsch matrix-fill controller: walks cells (1,1)..(N,N) row-major,
// fetches neighbours, computes the saturated max score and traceback direction.
//
// state   | meaning
// IDLE    | waiting for start, all outputs low
// READ    | neighbour fetch requested, waiting for signal
// CALC    | scoring of latched neighbours, register max/dir
// WRITE   | one-cycle write of max/dir at (i,j)
// NEXT    | one-cycle index advance
// DONE    | fill complete, indices hold N, waiting for restart
module score_fill_controller #(
  parameter int N        = 128,
  parameter int BitAddr  = $clog2(N + 1),
  parameter int MATCH    = 1,
  parameter int MISMATCH = -1,
  parameter int GAP      = -2
) (
  input  logic clk,
  input  logic rst,
  score_fill_if.master bus
);
  localparam int IW = BitAddr + 1;
  localparam logic signed [9:0] MATCH_W    = 10'(MATCH);
  localparam logic signed [9:0] MISMATCH_W = 10'(MISMATCH);
  localparam logic signed [9:0] GAP_W      = 10'(GAP);
  localparam logic [IW-1:0]     N_IDX      = IW'(N);
  localparam logic [IW-1:0]     ONE_IDX    = IW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CALC, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     i_q, i_d, j_q, j_d;
  logic signed [8:0] max_q, max_d;
  logic [1:0]        dir_q, dir_d;
  logic signed [8:0] diag_q, diag_d, up_q, up_d, left_q, left_d;
  logic              eq_q, eq_d;

  logic signed [9:0] d_raw, u_raw, l_raw;
  logic signed [8:0] d_sat, u_sat, l_sat;

  // Clamp a 10-bit intermediate score into the 9-bit score range.
  function automatic logic signed [8:0] sat9(input logic signed [9:0] v);
    if (v > 10'sd255)       return 9'sd255;
    else if (v < -10'sd256) return -9'sd256;
    else                    return $signed(v[8:0]);
  endfunction

  // Candidate scores from the latched neighbours, widened so overflow is visible.
  always_comb begin
    d_raw = $signed({diag_q[8], diag_q}) + (eq_q ? MATCH_W : MISMATCH_W);
    u_raw = $signed({up_q[8], up_q}) + GAP_W;
    l_raw = $signed({left_q[8], left_q}) + GAP_W;
    d_sat = sat9(d_raw);
    u_sat = sat9(u_raw);
    l_sat = sat9(l_raw);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      max_q   <= '0;
      dir_q   <= '0;
      diag_q  <= '0;
      up_q    <= '0;
      left_q  <= '0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      max_q   <= max_d;
      dir_q   <= dir_d;
      diag_q  <= diag_d;
      up_q    <= up_d;
      left_q  <= left_d;
      eq_q    <= eq_d;
    end
  end

  // Next-state, index walk and score selection.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    max_d   = max_q;
    dir_d   = dir_q;
    diag_d  = diag_q;
    up_d    = up_q;
    left_d  = left_q;
    eq_d    = eq_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_READ;
          i_d     = ONE_IDX;
          j_d     = ONE_IDX;
        end
      end
      S_READ: begin
        if (bus.signal) begin
          diag_d  = bus.diag;
          up_d    = bus.up;
          left_d  = bus.left;
          eq_d    = (bus.char_a == bus.char_b);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        // Ties resolve toward diag, then up.
        if (d_sat >= u_sat && d_sat >= l_sat) begin
          max_d = d_sat;
          dir_d = 2'b00;
        end else if (u_sat >= l_sat) begin
          max_d = u_sat;
          dir_d = 2'b01;
        end else begin
          max_d = l_sat;
          dir_d = 2'b10;
        end
        state_d = S_WRITE;
      end
      S_WRITE: state_d = S_NEXT;
      S_NEXT: begin
        if (j_q < N_IDX) begin
          j_d     = j_q + ONE_IDX;
          state_d = S_READ;
        end else if (i_q < N_IDX) begin
          j_d     = ONE_IDX;
          i_d     = i_q + ONE_IDX;
          state_d = S_READ;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    bus.en_read      = (state_q == S_READ);
    bus.en_ins       = (state_q == S_WRITE);
    bus.we           = (state_q == S_WRITE);
    bus.dir_valid    = (state_q == S_WRITE);
    bus.change_index = (state_q == S_NEXT);
    bus.busy         = (state_q == S_READ) || (state_q == S_CALC) ||
                       (state_q == S_WRITE) || (state_q == S_NEXT);
    bus.done         = (state_q == S_DONE);
    bus.i            = i_q;
    bus.j            = j_q;
    bus.max          = max_q;
    bus.dir          = dir_q;
  end
endmodule

// File: tb/tb_score_fill_controller.sv
// Scoreboard bench for score_fill_controller with N=4: directed corner cells,
// randomized neighbour scores and fetch latencies, mid-fill reset and restart.
module tb_score_fill_controller;
  localparam int NT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  score_fill_if #(.N(NT)) bus();
  score_fill_controller #(.N(NT)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int i;
    int j;
    int mx;
    int dr;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  int we_cnt   = 0;
  int ci_cnt   = 0;

  int dd[5] = '{3, 0, -5, 255, -256};
  int ud[5] = '{5, 1, 1, 0, -256};
  int ld[5] = '{0, 1, 3, 0, -256};
  int ad[5] = '{2, 0, 0, 1, 3};
  int bd[5] = '{2, 1, 1, 1, 2};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 255) return 255;
    if (v < -256) return -256;
    return v;
  endfunction

  // Cell k of the row-major walk, scored from the recurrence rules.
  function automatic exp_t model(input int k, input int dg, input int up, input int lf,
                                 input int a, input int b);
    exp_t e;
    int d, u, l, mx;
    d  = clamp(dg + ((a == b) ? 1 : -1));
    u  = clamp(up - 2);
    l  = clamp(lf - 2);
    mx = d;
    if (u > mx) mx = u;
    if (l > mx) mx = l;
    e.i  = k / NT + 1;
    e.j  = k % NT + 1;
    e.mx = mx;
    e.dr = (d == mx) ? 0 : ((u == mx) ? 1 : 2);
    return e;
  endfunction

  // Monitor: write pulses are matched against the scoreboard queue.
  always @(negedge clk) begin
    int hot;
    exp_t e;
    hot = int'(bus.en_read) + int'(bus.en_ins) + int'(bus.change_index);
    if (hot != 0) chk("strobe_exclusive", hot, 1);
    if (bus.change_index) ci_cnt++;
    if (bus.we) begin
      we_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_we", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("we_i", int'(bus.i), e.i);
        chk("we_j", int'(bus.j), e.j);
        chk("we_max", int'(bus.max), e.mx);
        chk("we_dir", int'(bus.dir), e.dr);
        chk("we_en_ins", int'(bus.en_ins), 1);
        chk("we_dir_valid", int'(bus.dir_valid), 1);
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_en_read"}, int'(bus.en_read), 0);
    chk({tag, "_en_ins"}, int'(bus.en_ins), 0);
    chk({tag, "_we"}, int'(bus.we), 0);
    chk({tag, "_change_index"}, int'(bus.change_index), 0);
    chk({tag, "_i"}, int'(bus.i), 0);
    chk({tag, "_j"}, int'(bus.j), 0);
    chk({tag, "_max"}, int'(bus.max), 0);
    chk({tag, "_dir"}, int'(bus.dir), 0);
    chk({tag, "_dir_valid"}, int'(bus.dir_valid), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
  endtask

  task automatic run_fill(input bit directed, input int abort_at);
    int dly, cnt, a, b, dg, up, lf;
    exp_t e;
    we_cnt = 0;
    ci_cnt = 0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("start_busy", int'(bus.busy), 1);
    chk("start_done", int'(bus.done), 0);
    chk("start_i", int'(bus.i), 1);
    chk("start_j", int'(bus.j), 1);
    for (int k = 0; k < NT * NT; k++) begin
      cnt = 0;
      while (!bus.en_read && cnt < 10) begin
        @(posedge clk); #1;
        cnt++;
      end
      if (!bus.en_read) begin
        chk("en_read_timeout", int'(bus.en_read), 1);
        return;
      end
      dly = directed ? 2 : int'($urandom_range(0, 4));
      for (int c = 0; c < dly; c++) begin
        bus.start = ($urandom_range(0, 2) == 0);
        @(posedge clk); #1;
      end
      bus.start = 1'b0;
      if (directed && k < 5) begin
        dg = dd[k]; up = ud[k]; lf = ld[k]; a = ad[k]; b = bd[k];
      end else begin
        dg = int'($urandom_range(0, 511)) - 256;
        up = int'($urandom_range(0, 511)) - 256;
        lf = int'($urandom_range(0, 511)) - 256;
        a  = int'($urandom_range(0, 3));
        b  = int'($urandom_range(0, 3));
      end
      e = model(k, dg, up, lf, a, b);
      sb.push_back(e);
      bus.diag   = 9'(dg);
      bus.up     = 9'(up);
      bus.left   = 9'(lf);
      bus.char_a = 2'(a);
      bus.char_b = 2'(b);
      bus.signal = 1'b1;
      @(posedge clk); #1;
      chk("en_read_drop", int'(bus.en_read), 0);
      // Junk fetch strobe while calculating must be ignored.
      bus.diag   = 9'($urandom_range(0, 511));
      bus.up     = 9'($urandom_range(0, 511));
      bus.left   = 9'($urandom_range(0, 511));
      bus.char_a = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      bus.signal = 1'b0;
      if (k == abort_at) begin
        cnt = 0;
        while (!bus.we && cnt < 10) begin
          @(posedge clk); #1;
          cnt++;
        end
        chk("abort_in_write", int'(bus.we), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("abort");
        rst = 1'b0;
        sb.delete();
        return;
      end
    end
    cnt = 0;
    while (!bus.done && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("fill_done", int'(bus.done), 1);
    chk("fill_busy", int'(bus.busy), 0);
    chk("fill_i", int'(bus.i), NT);
    chk("fill_j", int'(bus.j), NT);
    chk("fill_we_pulses", we_cnt, NT * NT);
    chk("fill_ci_pulses", ci_cnt, NT * NT);
    chk("fill_sb_left", sb.size(), 0);
    @(posedge clk); #1;
    chk("done_level", int'(bus.done), 1);
  endtask

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.signal = 1'b0;
    bus.diag   = '0;
    bus.up     = '0;
    bus.left   = '0;
    bus.char_a = '0;
    bus.char_b = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_zero("reset");
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_en_read", int'(bus.en_read), 0);

    run_fill(1'b1, -1);
    run_fill(1'b0, 6);

    repeat (2) @(posedge clk);
    #1;
    chk("post_abort_busy", int'(bus.busy), 0);
    chk("post_abort_i", int'(bus.i), 0);
    run_fill(1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
